decoder_scan: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder; successor of the team's 2-to-4 enable decoder.
- Direct mode: decodes a handshaked select index.
- Scan mode: auto-sequences through all outputs with a programmable dwell, for display/row multiplexing.
- Sits between control logic and one-hot strobes (digit enables, row selects, chip selects).

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_scan_dwell_counter.sv | 27 ++
 rtl/decoder_scan.sv | 93 +++++++++
 tb/tb_decoder_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared FSM type, counter width and one-hot helper for decoder_scan
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    localparam int CNT_W     = 16;
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // Callers cast the result down to their own 2**SEL_W output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_dwell_counter.sv
// rtl/decoder_scan_dwell_counter.sv - dwell counter with enable, clear and terminal-count pulse
module dwell_counter #(
    parameter int CNT_W = 16,
    parameter int DWELL = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with handshaked direct mode and timed auto-scan
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_mode,
    input  logic                i_sel_valid,
    input  logic [SEL_W-1:0]    i_sel,
    output logic                o_sel_ready,
    output logic [2**SEL_W-1:0] o_y,
    output logic [SEL_W-1:0]    o_cur_idx,
    output logic                o_wrap
);

    localparam int               OUT_W   = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] Y_IDLE  = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_cur_idx, w_idx_nxt;
    logic [OUT_W-1:0] r_y, w_dec;
    logic             r_wrap;
    logic             w_accept, w_cnt_en, w_cnt_clr, w_tc;

    assign o_sel_ready = ~i_mode;
    assign w_accept    = i_sel_valid & ~i_mode;
    // Counter only runs while actually scanning; any other state keeps it cleared
    // so a fresh scan always starts a full dwell from the current index.
    assign w_cnt_en    = i_en & i_mode & (r_state == ST_SCAN);
    assign w_cnt_clr   = (r_state != ST_SCAN);

    dwell_counter #(
        .CNT_W(CNT_W),
        .DWELL(DWELL)
    ) u_dwell (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en (w_cnt_en),
        .i_clr(w_cnt_clr),
        .o_tc (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_cur_idx;
        // Handshakes load an index even while blanked; mode changes wait for en.
        if (w_accept && r_state == ST_IDLE) begin
            w_state_nxt = ST_DIRECT;
        end
        if (i_en) begin
            if (i_mode) begin
                w_state_nxt = ST_SCAN;
            end else if (r_state == ST_SCAN) begin
                w_state_nxt = ST_DIRECT;
            end
        end
        if (w_accept) begin
            w_idx_nxt = i_sel;
        end else if (w_tc) begin
            w_idx_nxt = r_cur_idx + 1'b1;
        end
        w_dec = OUT_W'(onehot(MAX_SEL_W'(w_idx_nxt)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cur_idx <= '0;
            r_y       <= Y_IDLE;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_idx <= w_idx_nxt;
            r_wrap    <= w_tc && (r_cur_idx == IDX_MAX);
            if (!i_en || w_state_nxt == ST_IDLE) begin
                r_y <= Y_IDLE;
            end else begin
                r_y <= ACTIVE_LOW ? ~w_dec : w_dec;
            end
        end
    end

    assign o_y       = r_y;
    assign o_cur_idx = r_cur_idx;
    assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - self-checking bench for decoder_scan across three parameter sets
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [3];
    logic       en   [3];
    logic       mode [3];
    logic       sv   [3];
    logic [7:0] sel  [3];

    logic [3:0] y0, y1;
    logic [7:0] y2;
    logic [1:0] ci0, ci1;
    logic [2:0] ci2;
    logic       rdy0, rdy1, rdy2, wr0, wr1, wr2;

    decoder_scan #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_en(en[0]), .i_mode(mode[0]),
        .i_sel_valid(sv[0]), .i_sel(sel[0][1:0]), .o_sel_ready(rdy0),
        .o_y(y0), .o_cur_idx(ci0), .o_wrap(wr0));

    decoder_scan #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_en(en[1]), .i_mode(mode[1]),
        .i_sel_valid(sv[1]), .i_sel(sel[1][1:0]), .o_sel_ready(rdy1),
        .o_y(y1), .o_cur_idx(ci1), .o_wrap(wr1));

    decoder_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_en(en[2]), .i_mode(mode[2]),
        .i_sel_valid(sv[2]), .i_sel(sel[2][2:0]), .o_sel_ready(rdy2),
        .o_y(y2), .o_cur_idx(ci2), .o_wrap(wr2));

    logic [7:0] a_y   [3];
    logic [2:0] a_ci  [3];
    logic       a_wr  [3];
    logic       a_rdy [3];
    assign a_y[0] = {4'b0, y0};
    assign a_y[1] = {4'b0, y1};
    assign a_y[2] = y2;
    assign a_ci[0] = {1'b0, ci0};
    assign a_ci[1] = {1'b0, ci1};
    assign a_ci[2] = ci2;
    assign a_wr[0] = wr0;
    assign a_wr[1] = wr1;
    assign a_wr[2] = wr2;
    assign a_rdy[0] = rdy0;
    assign a_rdy[1] = rdy1;
    assign a_rdy[2] = rdy2;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: index advances once per DWELL enabled scan cycles counted since scan entry.
    int p_sw [3] = '{2, 2, 3};
    int p_dw [3] = '{4, 1, 4};
    int p_al [3] = '{0, 1, 0};

    int m_idx [3];
    int m_el  [3];
    int m_y   [3];
    bit m_started [3];
    bit m_scan    [3];
    bit m_wrap    [3];

    function automatic int shown(int k, bit on, int idx);
        int n    = 1 << p_sw[k];
        int mask = (1 << n) - 1;
        int raw  = on ? (1 << idx) : 0;
        return (p_al[k] != 0) ? (~raw & mask) : raw;
    endfunction

    task automatic model_step(int k);
        int n = 1 << p_sw[k];
        if (rst[k]) begin
            m_idx[k] = 0; m_el[k] = 0; m_started[k] = 0; m_scan[k] = 0; m_wrap[k] = 0;
        end else begin
            m_wrap[k] = 0;
            if (sv[k] && !mode[k]) begin
                m_idx[k]     = int'(sel[k]) % n;
                m_started[k] = 1;
            end
            if (en[k]) begin
                if (mode[k] && !m_scan[k]) begin
                    m_scan[k] = 1; m_el[k] = 0; m_started[k] = 1;
                end else if (mode[k]) begin
                    m_el[k]++;
                    if (m_el[k] % p_dw[k] == 0) begin
                        m_wrap[k] = (m_idx[k] == n - 1);
                        m_idx[k]  = (m_idx[k] + 1) % n;
                    end
                end else begin
                    m_scan[k] = 0;
                end
            end
        end
        m_y[k] = shown(k, en[k] && m_started[k] && !rst[k], m_idx[k]);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d_y", k), 32'(a_y[k]), m_y[k]);
            chk($sformatf("dut%0d_cur_idx", k), 32'(a_ci[k]), m_idx[k]);
            chk($sformatf("dut%0d_wrap", k), 32'(a_wr[k]), 32'(m_wrap[k]));
            chk($sformatf("dut%0d_sel_ready", k), 32'(a_rdy[k]), 32'(!mode[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; en[k] = 1'b0; mode[k] = 1'b0; sv[k] = 1'b0; sel[k] = 8'd0;
        end
        tick(); tick();
        chk("rst_y0", 32'(y0), 32'h0);
        chk("rst_y1_active_low", 32'(y1), 32'hF);
        chk("rst_idx0", 32'(ci0), 32'h0);
        chk("rst_wrap0", 32'(wr0), 32'h0);

        rst[0] = 1'b0; en[0] = 1'b1; sel[0] = 8'd2; sv[0] = 1'b1;
        tick();
        chk("direct_y", 32'(y0), 32'b0100);
        chk("direct_idx", 32'(ci0), 32'd2);
        sv[0] = 1'b0;
        tick();
        chk("direct_hold_y", 32'(y0), 32'b0100);
        en[0] = 1'b0;
        tick();
        chk("blank_y", 32'(y0), 32'h0);
        sel[0] = 8'd3; sv[0] = 1'b1;
        tick();
        chk("blank_accept_y", 32'(y0), 32'h0);
        chk("blank_accept_idx", 32'(ci0), 32'd3);
        sv[0] = 1'b0; en[0] = 1'b1;
        tick();
        chk("unblank_y", 32'(y0), 32'b1000);
        sel[0] = 8'd0; sv[0] = 1'b1;
        tick();
        chk("load0_y", 32'(y0), 32'b0001);

        // Scan with a pending select that must be ignored.
        sel[0] = 8'd2; mode[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("scan_y", 32'(y0), 32'(1 << ((i / 4) % 4)));
            chk("scan_wrap", 32'(wr0), 32'(i == 16));
            chk("scan_ready", 32'(rdy0), 32'h0);
        end
        sv[0] = 1'b0; mode[0] = 1'b0;
        tick();
        chk("term_hold_y", 32'(y0), 32'b0001);
        chk("term_hold_idx", 32'(ci0), 32'd0);
        chk("term_hold_wrap", 32'(wr0), 32'h0);

        mode[0] = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("pre_rst_idx", 32'(ci0), 32'd3);
        rst[0] = 1'b1;
        tick();
        chk("midscan_rst_y", 32'(y0), 32'h0);
        chk("midscan_rst_idx", 32'(ci0), 32'h0);
        chk("midscan_rst_wrap", 32'(wr0), 32'h0);
        chk("midscan_rst_ready", 32'(rdy0), 32'h0);
        mode[0] = 1'b0;
        #1;
        chk("ready_follows_mode", 32'(rdy0), 32'h1);

        rst[1] = 1'b0; en[1] = 1'b1; mode[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("fast_scan_y", 32'(y1), 32'(4'hF ^ (4'(1) << (i % 4))));
            chk("fast_scan_wrap", 32'(wr1), 32'((i > 0) && (i % 4 == 0)));
        end
        en[1] = 1'b0;
        tick();
        chk("fast_blank_y", 32'(y1), 32'hF);
        tick();
        en[1] = 1'b1;
        tick(); tick(); tick();
        rst[1] = 1'b1;

        rst[2] = 1'b0; en[2] = 1'b1; sv[2] = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel[2] = 8'(s);
            tick();
            chk("w3_y", 32'(y2), 32'(1 << s));
            chk("w3_idx", 32'(ci2), 32'(s));
            chk("w3_onehot", 32'($countones(y2)), 32'd1);
        end
        sv[2] = 1'b0;
        tick();
        chk("w3_hold_y", 32'(y2), 32'h80);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
